// File: rtl/shift_share_arbiter.sv
// rtl/shift_share_arbiter.sv - one shared left shifter arbitrated among NUM_PORTS elastic requesters
// Optional macro SHIFT_SHARE_RR_EN selects round-robin arbitration (default: fixed priority, lowest index).
module shift_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] ins_lhs,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] ins_rhs,
    input  logic [NUM_PORTS-1:0]            ins_valid,
    output logic [NUM_PORTS-1:0]            ins_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] outs,
    output logic [NUM_PORTS-1:0]            outs_valid,
    input  logic [NUM_PORTS-1:0]            outs_ready
);
    localparam int TAG_W = $clog2(NUM_PORTS);
    localparam logic [DATA_WIDTH:0] DW_L = DATA_WIDTH;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  res_q, res_d;
    logic [TAG_W-1:0]       owner_q, owner_d;
    logic [TAG_W-1:0]       last_q, last_d;

    logic                   can_accept;
    logic                   grant_any;
    logic                   do_grant;
    logic [TAG_W-1:0]       grant;
    logic [DATA_WIDTH-1:0]  sel_lhs, sel_rhs, shifted;

`ifdef SHIFT_SHARE_RR_EN
    int                     rr_idx;
    logic [TAG_W-1:0]       rr_tag;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        grant_any = 1'b0;
        grant     = '0;
        rr_idx    = 0;
        rr_tag    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            rr_idx = (int'(last_q) + 1 + k) % NUM_PORTS;
            rr_tag = TAG_W'(rr_idx);
            if (!grant_any && ins_valid[rr_tag]) begin
                grant_any = 1'b1;
                grant     = rr_tag;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last_q;

    always_comb begin
        grant_any = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!grant_any && ins_valid[k]) begin
                grant_any = 1'b1;
                grant     = TAG_W'(k);
            end
        end
    end
`endif

    assign can_accept = (state_q == IDLE) || ((state_q == BUSY) && outs_ready[owner_q]);
    assign do_grant   = can_accept && grant_any && !rst;

    always_comb begin
        sel_lhs = '0;
        sel_rhs = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == TAG_W'(i)) begin
                sel_lhs = ins_lhs[i*DATA_WIDTH +: DATA_WIDTH];
                sel_rhs = ins_rhs[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Full-width compare so oversized shift amounts are never truncated into range.
    assign shifted = ({1'b0, sel_rhs} >= DW_L) ? '0 : (sel_lhs << sel_rhs);

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (do_grant) begin
            res_d   = shifted;
            owner_d = grant;
            last_d  = grant;
            state_d = BUSY;
        end else if ((state_q == BUSY) && outs_ready[owner_q]) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            owner_q <= '0;
            last_q  <= TAG_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        ins_ready  = '0;
        outs_valid = '0;
        outs       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (do_grant && (grant == TAG_W'(i))) begin
                ins_ready[i] = 1'b1;
            end
            if ((state_q == BUSY) && (owner_q == TAG_W'(i))) begin
                outs_valid[i]                      = 1'b1;
                outs[i*DATA_WIDTH +: DATA_WIDTH]   = res_q;
            end
        end
    end
endmodule

// File: tb/tb_shift_share_arbiter.sv
// tb/tb_shift_share_arbiter.sv - directed self-checking bench for shift_share_arbiter
module tb_shift_share_arbiter;
    logic        clk;
    logic        rst;
    logic [63:0] ins_lhs;
    logic [63:0] ins_rhs;
    logic [1:0]  ins_valid;
    logic [1:0]  ins_ready;
    logic [63:0] outs;
    logic [1:0]  outs_valid;
    logic [1:0]  outs_ready;

    int checks;
    int errors;

    shift_share_arbiter #(.DATA_WIDTH(32), .NUM_PORTS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_lhs    (ins_lhs),
        .ins_rhs    (ins_rhs),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        ins_valid  = 2'b11;
        ins_lhs    = {32'd5, 32'd5};
        ins_rhs    = {32'd1, 32'd1};
        outs_ready = 2'b11;
        tick();
        tick();
        settle();
        checks++;
        if (ins_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ins_ready got %b exp 00", ins_ready);
        end
        checks++;
        if (outs_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_outs_valid got %b exp 00", outs_valid);
        end
        checks++;
        if (outs !== 64'd0) begin
            errors++;
            $display("FAIL reset_outs got %h exp 0", outs);
        end
        rst       = 1'b0;
        ins_valid = 2'b00;
        tick();
    endtask

    task automatic test_single_op();
        ins_lhs    = {32'd0, 32'd1};
        ins_rhs    = {32'd0, 32'd4};
        ins_valid  = 2'b01;
        outs_ready = 2'b11;
        settle();
        checks++;
        if (ins_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ins_ready got %b exp 01", ins_ready);
        end
        tick();
        ins_valid = 2'b00;
        settle();
        checks++;
        if (outs_valid !== 2'b01) begin
            errors++;
            $display("FAIL single_outs_valid got %b exp 01", outs_valid);
        end
        checks++;
        if (outs !== {32'd0, 32'd16}) begin
            errors++;
            $display("FAIL single_outs got %h exp %h", outs, {32'd0, 32'd16});
        end
        tick();
        settle();
        checks++;
        if (outs_valid !== 2'b00) begin
            errors++;
            $display("FAIL single_idle got %b exp 00", outs_valid);
        end
    endtask

    task automatic test_width_bounds();
        logic [31:0] lhs_v [5];
        logic [31:0] rhs_v [5];
        logic [31:0] exp_v [5];
        lhs_v = '{32'd3, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'h0000_00FF};
        rhs_v = '{32'd31, 32'd32,       32'hFFFF_FFFF, 32'd0,         32'd33};
        exp_v = '{32'h8000_0000, 32'd0, 32'd0,         32'hFFFF_FFFF, 32'd0};
        outs_ready = 2'b11;
        for (int i = 0; i < 5; i++) begin
            ins_lhs   = {lhs_v[i], 32'd0};
            ins_rhs   = {rhs_v[i], 32'd0};
            ins_valid = 2'b10;
            settle();
            checks++;
            if (ins_ready !== 2'b10) begin
                errors++;
                $display("FAIL width_ins_ready[%0d] got %b exp 10", i, ins_ready);
            end
            tick();
            ins_valid = 2'b00;
            settle();
            checks++;
            if (outs_valid !== 2'b10 || outs[63:32] !== exp_v[i] || outs[31:0] !== 32'd0) begin
                errors++;
                $display("FAIL width_result[%0d] got v=%b d=%h exp v=10 d=%h", i, outs_valid, outs, exp_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_arbitration();
        ins_lhs    = {32'd1, 32'd1};
        ins_rhs    = {32'd2, 32'd1};
        ins_valid  = 2'b11;
        outs_ready = 2'b11;
`ifdef SHIFT_SHARE_RR_EN
        begin
            logic [1:0] exp_g [4];
            exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
            for (int c = 0; c < 4; c++) begin
                settle();
                checks++;
                if (ins_ready !== exp_g[c]) begin
                    errors++;
                    $display("FAIL rr_grant[%0d] got %b exp %b", c, ins_ready, exp_g[c]);
                end
                if (c > 0) begin
                    checks++;
                    if (outs_valid !== exp_g[c-1] ||
                        outs !== ((exp_g[c-1] == 2'b01) ? {32'd0, 32'd2} : {32'd4, 32'd0})) begin
                        errors++;
                        $display("FAIL rr_result[%0d] got v=%b d=%h exp v=%b", c, outs_valid, outs, exp_g[c-1]);
                    end
                end
                tick();
            end
            ins_valid = 2'b00;
            settle();
            checks++;
            if (outs_valid !== 2'b10 || outs !== {32'd4, 32'd0}) begin
                errors++;
                $display("FAIL rr_last got v=%b d=%h exp v=10 d=%h", outs_valid, outs, {32'd4, 32'd0});
            end
        end
`else
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++;
            if (ins_ready !== 2'b01) begin
                errors++;
                $display("FAIL fixed_grant[%0d] got %b exp 01", c, ins_ready);
            end
            if (c > 0) begin
                checks++;
                if (outs_valid !== 2'b01 || outs !== {32'd0, 32'd2}) begin
                    errors++;
                    $display("FAIL fixed_result[%0d] got v=%b d=%h exp v=01 d=2", c, outs_valid, outs);
                end
            end
            tick();
        end
        ins_valid = 2'b00;
`endif
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        ins_lhs    = {32'd7, 32'd9};
        ins_rhs    = {32'd3, 32'd1};
        ins_valid  = 2'b10;
        outs_ready = 2'b00;
        settle();
        checks++;
        if (ins_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_setup got %b exp 10", ins_ready);
        end
        tick();
        ins_valid  = 2'b01;
        outs_ready = 2'b01;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (ins_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_stall_ready[%0d] got %b exp 00", c, ins_ready);
            end
            checks++;
            if (outs_valid !== 2'b10 || outs !== {32'd56, 32'd0}) begin
                errors++;
                $display("FAIL bp_stall_hold[%0d] got v=%b d=%h exp v=10 d=%h", c, outs_valid, outs, {32'd56, 32'd0});
            end
            tick();
        end
        outs_ready = 2'b10;
        settle();
        checks++;
        if (ins_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got %b exp 01", ins_ready);
        end
        tick();
        ins_valid  = 2'b00;
        outs_ready = 2'b11;
        settle();
        checks++;
        if (outs_valid !== 2'b01 || outs !== {32'd0, 32'd18}) begin
            errors++;
            $display("FAIL bp_after got v=%b d=%h exp v=01 d=%h", outs_valid, outs, {32'd0, 32'd18});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        ins_lhs    = {32'd1, 32'd3};
        ins_rhs    = {32'd8, 32'd2};
        ins_valid  = 2'b10;
        outs_ready = 2'b00;
        tick();
        ins_valid = 2'b00;
        settle();
        checks++;
        if (outs_valid !== 2'b10 || outs !== {32'd256, 32'd0}) begin
            errors++;
            $display("FAIL rstmid_busy got v=%b d=%h exp v=10", outs_valid, outs);
        end
        rst       = 1'b1;
        ins_valid = 2'b11;
        settle();
        checks++;
        if (ins_ready !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_ready_in_rst got %b exp 00", ins_ready);
        end
        tick();
        settle();
        checks++;
        if (outs_valid !== 2'b00 || outs !== 64'd0 || ins_ready !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_cleared got v=%b r=%b d=%h exp all 0", outs_valid, ins_ready, outs);
        end
        rst        = 1'b0;
        outs_ready = 2'b11;
        settle();
        checks++;
        if (ins_ready !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_first_grant got %b exp 01", ins_ready);
        end
        tick();
        ins_valid = 2'b00;
        settle();
        checks++;
        if (outs_valid !== 2'b01 || outs !== {32'd0, 32'd12}) begin
            errors++;
            $display("FAIL rstmid_result got v=%b d=%h exp v=01 d=%h", outs_valid, outs, {32'd0, 32'd12});
        end
        tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        ins_lhs    = '0;
        ins_rhs    = '0;
        ins_valid  = '0;
        outs_ready = '0;
        test_reset();
        test_single_op();
        test_width_bounds();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
